// File: rtl/rgb_column_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_column_feeder_pkg : shared constants for the RGB column feeder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rgb_column_feeder_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int COL_ROWS       = 3;
  localparam int NUM_CH         = 3;
  localparam int DEF_IMG_WIDTH  = 224;
  localparam int DEF_IMG_HEIGHT = 224;

  // Row slots inside a packed column word, lowest slot is the oldest row
  localparam int ROW_OLD = 0;
  localparam int ROW_MID = 1;
  localparam int ROW_CUR = 2;

endpackage
`default_nettype wire

// File: rtl/rgb_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_line_buffer : two-row shift memory for one colour channel        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rgb_line_buffer
  import rgb_column_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int XW         = $clog2(IMG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [XW-1:0]         x,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] row0,
  output logic [DATA_WIDTH-1:0] row1
);

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  // Reads are combinational so the same-cycle write sees the old contents
  assign row0 = lb0[x];
  assign row1 = lb1[x];

  always_ff @(posedge clk) begin
    if (we) begin
      lb0[x] <= lb1[x];
      lb1[x] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgb_column_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_column_feeder : raster RGB stream to 3-row columns + conv window |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rgb_column_feeder
  import rgb_column_feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [DATA_WIDTH-1:0]          pix_r,
  input  logic [DATA_WIDTH-1:0]          pix_g,
  input  logic [DATA_WIDTH-1:0]          pix_b,
  output logic [COL_ROWS*DATA_WIDTH-1:0] input_col_r,
  output logic [COL_ROWS*DATA_WIDTH-1:0] input_col_g,
  output logic [COL_ROWS*DATA_WIDTH-1:0] input_col_b,
  output logic                           col,
  output logic                           start_conv,
  output logic                           frame_done
);

  localparam int XW  = $clog2(IMG_WIDTH);
  localparam int YW  = $clog2(IMG_HEIGHT);
  localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [2:0]     state;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [DCW-1:0] dcnt;

  logic accept;
  logic stream_acc;
  logic x_last;
  logic y_last;

  logic [DATA_WIDTH-1:0]          pix_ch [NUM_CH];
  logic [DATA_WIDTH-1:0]          rd0    [NUM_CH];
  logic [DATA_WIDTH-1:0]          rd1    [NUM_CH];
  logic [COL_ROWS*DATA_WIDTH-1:0] col_q  [NUM_CH];

  assign pix_ready  = (state == ST_FILL) || (state == ST_STREAM);
  assign start_conv = (state == ST_STREAM) || (state == ST_DRAIN);
  assign frame_done = (state == ST_DONE);

  assign accept     = pix_valid && pix_ready;
  assign stream_acc = accept && (state == ST_STREAM);
  assign x_last     = (x == XW'(IMG_WIDTH - 1));
  assign y_last     = (y == YW'(IMG_HEIGHT - 1));

  assign pix_ch[0] = pix_r;
  assign pix_ch[1] = pix_g;
  assign pix_ch[2] = pix_b;

  assign input_col_r = col_q[0];
  assign input_col_g = col_q[1];
  assign input_col_b = col_q[2];

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      rgb_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH),
        .XW         (XW)
      ) u_lb (
        .clk  (clk),
        .we   (accept),
        .x    (x),
        .din  (pix_ch[c]),
        .row0 (rd0[c]),
        .row1 (rd1[c])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) col_q[c] <= '0;
    end else begin
      col <= stream_acc;
      if (stream_acc) begin
        for (int c = 0; c < NUM_CH; c++) begin
          col_q[c][ROW_CUR*DATA_WIDTH +: DATA_WIDTH] <= pix_ch[c];
          col_q[c][ROW_MID*DATA_WIDTH +: DATA_WIDTH] <= rd1[c];
          col_q[c][ROW_OLD*DATA_WIDTH +: DATA_WIDTH] <= rd0[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_FILL;
            x     <= '0;
            y     <= '0;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (accept) begin
            if (x_last) begin
              x <= '0;
              y <= y_last ? '0 : y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
            if (state == ST_FILL && x_last && y == YW'(1)) begin
              state <= ST_STREAM;
            end else if (state == ST_STREAM && x_last && y_last) begin
              state <= (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
              dcnt  <= '0;
            end
          end
        end
        // First DRAIN cycle coincides with the final col strobe
        ST_DRAIN: begin
          if (dcnt == DCW'(DRAIN_CYCLES)) state <= ST_DONE;
          else                            dcnt  <= dcnt + DCW'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
